triangle_duty_meter: RTL and testbench



---
 rtl/triangle_duty_meter.sv | 144 ++++++++++++++
 tb/tb_triangle_duty_meter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_duty_meter.sv
// triangle_duty_meter: measures one frame of a triangle-wave sample stream,
// finds the first maximum and its index, and converts that index back to
// the 0..STEPS duty code used by the waveform generator.
module triangle_duty_meter #(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int STEPS    = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic                     i_sof,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [3:0]               o_sel,
  output logic [ADDR_W-1:0]        o_peak_idx,
  output logic signed [DATA_W-1:0] o_peak_val,
  output logic                     o_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_CALC,
    S_DONE
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [ADDR_W-1:0]          cnt;
  logic signed [DATA_W-1:0]   max_val;
  logic [ADDR_W-1:0]          max_idx;
  logic                       pend;
  logic                       err_q;

  logic                       collecting;
  logic                       start;
  logic                       take;
  logic                       last;
  logic                       err_now;
  logic [ADDR_W+3:0]          prod;
  logic [3:0]                 sel_raw;
  logic [3:0]                 sel_calc;

  // Sample qualification. The peak/index are copied to the outputs at the
  // end of CALC, so the accumulator is free to take a new frame that starts
  // during CALC or DONE (pend marks such a frame until the FSM re-enters
  // ACCUM); this is what keeps back-to-back frames lossless.
  always_comb begin
    collecting = (state == S_ACCUM) || pend;
    start      = i_valid && i_sof;
    take       = i_valid && !i_sof && collecting;
    last       = take && (cnt == ADDR_W'(MEM_SIZE - 1));
    err_now    = start && collecting;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_ACCUM;
      S_ACCUM: if (last) state_nxt = S_CALC;
      S_CALC:  state_nxt = S_DONE;
      S_DONE:  state_nxt = (pend || start) ? S_ACCUM : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM-derived outputs.
  always_comb begin
    o_busy = (state != S_IDLE);
    o_done = (state == S_DONE);
  end

  // Frame accumulator: sample counter, running first maximum and its index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      max_val <= '0;
      max_idx <= '0;
      pend    <= 1'b0;
    end else begin
      pend <= (state == S_CALC) && start;
      if (start) begin
        cnt     <= ADDR_W'(1);
        max_val <= i_data;
        max_idx <= '0;
      end else if (take) begin
        if (i_data > max_val) begin
          max_val <= i_data;
          max_idx <= cnt;
        end
        cnt <= last ? '0 : cnt + ADDR_W'(1);
      end
    end
  end

  // Index-to-duty conversion: round(idx*STEPS/MEM_SIZE), saturated, and
  // forced to zero when the frame never rises above zero.
  always_comb begin
    prod    = (ADDR_W+4)'(max_idx) * (ADDR_W+4)'(STEPS)
            + (ADDR_W+4)'(MEM_SIZE / 2);
    sel_raw = prod[ADDR_W+3:ADDR_W];
    if (max_val[DATA_W-1] || (max_val == '0)) begin
      sel_calc = '0;
    end else if (sel_raw > 4'(STEPS)) begin
      sel_calc = 4'(STEPS);
    end else begin
      sel_calc = sel_raw;
    end
  end

  // Result registers, loaded on the CALC->DONE edge and held until the
  // next completed frame; error pulse one cycle after a mid-frame i_sof.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sel      <= '0;
      o_peak_idx <= '0;
      o_peak_val <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_now;
      if (state == S_CALC) begin
        o_sel      <= sel_calc;
        o_peak_idx <= max_idx;
        o_peak_val <= max_val;
      end
    end
  end

  assign o_err = err_q;

endmodule

// File: tb/tb_triangle_duty_meter.sv
// Self-checking bench for triangle_duty_meter: a frame-level reference model
// (sample queue per frame, result computed when the frame completes) checked
// against the DUT every cycle, plus literal expectations per scenario.
module tb_triangle_duty_meter;

  localparam int MEM = 1024;
  localparam int AW  = 10;
  localparam int DW  = 16;
  localparam int ST  = 10;

  logic                 clk;
  logic                 rst_n;
  logic                 i_valid;
  logic                 i_sof;
  logic signed [DW-1:0] i_data;
  logic                 o_busy;
  logic                 o_done;
  logic [3:0]           o_sel;
  logic [AW-1:0]        o_peak_idx;
  logic signed [DW-1:0] o_peak_val;
  logic                 o_err;

  triangle_duty_meter #(
    .MEM_SIZE(MEM),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .STEPS   (ST)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .i_sof     (i_sof),
    .i_data    (i_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_sel     (o_sel),
    .o_peak_idx(o_peak_idx),
    .o_peak_val(o_peak_val),
    .o_err     (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int                   cyc = 0;
  bit                   in_frame = 1'b0;
  logic signed [DW-1:0] fq[$];
  int                   done_at = -10;
  int                   err_at = -10;
  int                   res_sel = 0, res_idx = 0, res_val = 0;
  int                   exp_sel = 0, exp_idx = 0, exp_val = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      fq.delete();
      done_at = -10;
      err_at  = -10;
      exp_sel = 0;
      exp_idx = 0;
      exp_val = 0;
    end else begin
      cyc++;
      if (done_at == cyc) begin
        exp_sel = res_sel;
        exp_idx = res_idx;
        exp_val = res_val;
      end
      if (i_valid) begin
        if (i_sof) begin
          if (in_frame && fq.size() > 0) err_at = cyc;
          fq.delete();
          fq.push_back(i_data);
          in_frame = 1'b1;
        end else if (in_frame) begin
          fq.push_back(i_data);
        end
        if (in_frame && fq.size() == MEM) begin
          int best = 0;
          for (int i = 1; i < MEM; i++) if (fq[i] > fq[best]) best = i;
          res_idx = best;
          res_val = int'(fq[best]);
          res_sel = (best * ST + MEM / 2) / MEM;
          if (res_sel > ST) res_sel = ST;
          if (res_val <= 0) res_sel = 0;
          done_at  = cyc + 1;
          in_frame = 1'b0;
          fq.delete();
        end
      end
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int last_sent = 0;
  int done_cyc_q[$];
  int done_sel_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    chk("done",     int'(o_done), int'(done_at == cyc));
    chk("err",      int'(o_err),  int'(err_at == cyc));
    chk("busy",     int'(o_busy), int'(in_frame || done_at == cyc || done_at == cyc + 1));
    chk("sel",      int'(o_sel), exp_sel);
    chk("peak_idx", int'(o_peak_idx), exp_idx);
    chk("peak_val", int'(o_peak_val), exp_val);
    if (o_done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
      done_sel_q.push_back(int'(o_sel));
    end
    if (o_err) err_cnt++;
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    i_valid = v;
    i_sof   = s;
    i_data  = d;
    if (v) last_sent = cyc;
    @(negedge clk);
    compare();
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [DW-1:0] gen(input int sel, input int a);
    int p, v, vp;
    p  = sel * (MEM - 1) / ST;
    vp = (p == 0) ? 0 : 16 * p - 1;
    if (a <= p) v = (a == 0) ? 0 : 16 * a - 1;
    else        v = vp - 16 * (a - p);
    return DW'(v);
  endfunction

  function automatic logic [DW-1:0] plateau(input int a);
    int v;
    if (a < 300)       v = a * 100 / 300;
    else if (a <= 400) v = 100;
    else               v = 100 - (a - 400);
    return DW'(v);
  endfunction

  // mode 0: generator, 1: plateau, 2: random data
  task automatic send_frame(input int mode, input int sel, input int n, input int gap);
    for (int a = 0; a < n; a++) begin
      logic [DW-1:0] d;
      for (int g = 0; g < 8; g++) begin
        if ($urandom_range(99) < gap) step(1'b0, 1'b0, '0);
        else break;
      end
      if (mode == 0)      d = gen(sel, a);
      else if (mode == 1) d = plateau(a);
      else                d = DW'($urandom);
      step(1'b1, a == 0, d);
    end
  endtask

  task automatic wait_done(input int n0);
    int k = 0;
    while (done_cnt == n0 && k < 10) begin
      step(1'b0, 1'b0, '0);
      k++;
    end
    chk("done_seen", done_cnt, n0 + 1);
  endtask

  initial begin
    int n0, e0, q0;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_data  = '0;
    repeat (3) step(1'b0, 1'b0, '0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_sel",  int'(o_sel), 0);
    chk("rst_idx",  int'(o_peak_idx), 0);
    chk("rst_val",  int'(o_peak_val), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, '0);
    // stray non-sof samples in IDLE are ignored
    repeat (4) step(1'b1, 1'b0, 16'h1234);
    chk("idle_ignore", int'(o_busy), 0);

    // generator frames, sel 0..10
    for (int s = 0; s <= ST; s++) begin
      n0 = done_cnt;
      send_frame(0, s, MEM, 0);
      wait_done(n0);
      chk("gen_sel", int'(o_sel), s);
      if (s == 5) begin
        chk("gen5_idx", int'(o_peak_idx), 511);
        chk("gen5_val", int'(o_peak_val), 8175);
      end
      if (s == 10) chk("gen10_idx", int'(o_peak_idx), 1023);
      if (s == 0)  chk("gen0_val", int'(o_peak_val), 0);
    end

    // plateau: first maximum wins
    n0 = done_cnt;
    send_frame(1, 0, MEM, 0);
    wait_done(n0);
    chk("plat_idx", int'(o_peak_idx), 300);
    chk("plat_sel", int'(o_sel), 3);

    // gapped sel=7
    n0 = done_cnt;
    send_frame(0, 7, MEM, 50);
    wait_done(n0);
    chk("gap_sel", int'(o_sel), 7);
    chk("gap_latency", done_cyc_q[$] - last_sent, 2);

    // mid-frame sof at index 500, then sel=2
    n0 = done_cnt;
    e0 = err_cnt;
    send_frame(0, 6, 500, 0);
    send_frame(0, 2, MEM, 0);
    wait_done(n0);
    chk("abort_err", err_cnt - e0, 1);
    chk("abort_done", done_cnt - n0, 1);
    chk("abort_sel", int'(o_sel), 2);

    // reset at index 700
    n0 = done_cnt;
    send_frame(0, 6, 700, 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    @(negedge clk);
    compare();
    chk("mrst_busy", int'(o_busy), 0);
    chk("mrst_sel",  int'(o_sel), 0);
    chk("mrst_idx",  int'(o_peak_idx), 0);
    chk("mrst_val",  int'(o_peak_val), 0);
    repeat (2) step(1'b0, 1'b0, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) step(1'b0, 1'b0, '0);
    chk("mrst_nodone", done_cnt, n0);
    send_frame(0, 9, MEM, 0);
    wait_done(n0);
    chk("mrst_sel9", int'(o_sel), 9);

    // back-to-back sel=4 then sel=8
    n0 = done_cnt;
    q0 = done_cyc_q.size();
    send_frame(0, 4, MEM, 0);
    send_frame(0, 8, MEM, 0);
    wait_done(n0 + 1);
    chk("b2b_count", done_cnt - n0, 2);
    if (done_cyc_q.size() >= q0 + 2) begin
      chk("b2b_sel_a", done_sel_q[q0], 4);
      chk("b2b_sel_b", done_sel_q[q0 + 1], 8);
      chk("b2b_spacing", done_cyc_q[q0 + 1] - done_cyc_q[q0], MEM);
    end

    // random data frames, with a random restart inside the first one
    n0 = done_cnt;
    send_frame(2, 0, 1 + int'($urandom_range(MEM - 2)), 30);
    send_frame(2, 0, MEM, 30);
    wait_done(n0);
    n0 = done_cnt;
    send_frame(2, 0, MEM, 0);
    wait_done(n0);
    repeat (5) step(1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
